match_capture_fifo: RTL
=======================

MATCH_CAPTURE_FIFO -- requirements
Module: match_capture_fifo

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- DEPTH, 64, word entries; power of two, >= 4.
- WIDTH, 32, data word width.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, sole clock; all state updates on rising edge.
- rst, in, 1, asynchronous active-high reset.
- clear, in, 1, abort the in-progress capture.
- word_in, in, WIDTH, stream word from the MAC comparator data_out.
- word_valid, in, 1, word_in is valid this cycle.
- match, in, 1, comparator match flag, aligned with the first word of a flagged frame.
- frame_end, in, 1, with word_valid: word_in is the last word of its frame.
- rd_en, in, 1, pop the head word.
- rd_data, out, WIDTH, head word (show-ahead).
- rd_last, out, 1, head word is the last word of its frame.
- empty, out, 1, no committed word available.
- frame_count, out, log2(DEPTH)+1, committed frames not fully read.
- capturing, out, 1, FSM is in CAPTURE.
- dropped, out, 1, one-cycle pulse when a frame is discarded for overflow.

Function
REQ-003 Storage SHALL be DEPTH entries of {last, word}; wr_ptr, cmt_ptr and rd_ptr SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
REQ-004 The FSM SHALL have three states: IDLE, CAPTURE and DROP.
REQ-005 IDLE SHALL go to CAPTURE when word_valid=1, match=1 and frame_end=0, writing that word; with frame_end=1 the single word SHALL be written and committed, and the FSM SHALL stay in IDLE.
REQ-006 In CAPTURE, each word_valid=1 cycle SHALL write word_in at wr_ptr and increment wr_ptr; match is ignored.
REQ-007 A write with frame_end=1 SHALL store last=1, set cmt_ptr to the post-write wr_ptr, increment frame_count and return to IDLE; the committed words become readable the next cycle.
REQ-008 Overflow SHALL occur when a write is attempted with wr_ptr-rd_ptr==DEPTH, using pre-pop occupancy even if rd_en pops the same cycle; the word is not written, wr_ptr is rewound to cmt_ptr, dropped pulses and the FSM goes to DROP (or stays in IDLE if that word had frame_end=1).
REQ-009 DROP SHALL discard all words and return to IDLE on the cycle after word_valid=1 with frame_end=1.
REQ-010 clear=1 SHALL force IDLE and rewind wr_ptr to cmt_ptr, overriding any same-cycle write or commit; committed data, rd_ptr and frame_count are unaffected.
REQ-011 empty SHALL be (rd_ptr==cmt_ptr).
- rd_data and rd_last SHALL reflect entry rd_ptr combinationally and are don't-care when empty=1.
- rd_en=1 with empty=0 SHALL increment rd_ptr; rd_en with empty=1 SHALL be ignored.
REQ-012 Popping a word with last=1 SHALL decrement frame_count; a same-cycle commit and last-word pop SHALL leave it unchanged.
REQ-013 capturing SHALL be 1 exactly while the state is CAPTURE.

Reset
REQ-014 rst=1 SHALL immediately (asynchronously) reset:
- state to IDLE;
- all pointers and frame_count to 0;
- empty to 1, capturing to 0, dropped to 0.
REQ-015 Storage contents SHALL NOT be reset.
REQ-016 Reset asserted mid-capture SHALL lose the partial frame and all committed frames.

Configuration
REQ-017 When macro CAPTURE_DROP_COUNT_EN is defined, an output drop_count[15:0] SHALL exist:
- reset to 0;
- incremented on each dropped pulse;
- saturating at 16'hFFFF;
- without the macro the port and counter SHALL be absent and behaviour otherwise identical.

Verification
REQ-018 Reset then idle: empty=1, frame_count=0, capturing=0, dropped=0.
REQ-019 Words E5F60000 (match=1), then A1B2C3D4, then 00000000 (frame_end=1), one per cycle, all word_valid=1:
- next cycle empty=0, frame_count=1;
- three rd_en pops return those words in order, with rd_last=1 only on 00000000;
- frame_count then reads 0.
REQ-020 Words with match=0 in IDLE: nothing stored, empty stays 1.
REQ-021 DEPTH=64, 70-word matched frame with no reads:
- dropped pulses once, on word 65;
- empty stays 1;
- a following 2-word matched frame commits normally with frame_count=1;
- with CAPTURE_DROP_COUNT_EN, drop_count=1.
REQ-022 clear mid-frame after 2 words: capturing falls, empty stays 1; an earlier committed frame still reads back intact.
REQ-023 Commit of frame 2 in the same cycle as rd_en pops the last word of frame 1: frame_count unchanged at 1, empty=0.

Source files
------------

// File: rtl/match_capture_fifo.sv
// rtl/match_capture_fifo.sv - frame capture FIFO that stores only frames flagged by the MAC comparator
// Optional drop counter output enabled with CAPTURE_DROP_COUNT_EN.
module match_capture_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         word_in,
  input  logic                     word_valid,
  input  logic                     match,
  input  logic                     frame_end,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_last,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   frame_count,
  output logic                     capturing,
  output logic                     dropped
`ifdef CAPTURE_DROP_COUNT_EN
  ,
  output logic [15:0]              drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
  localparam logic [AW:0] PTR_DEPTH = (AW+1)'(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DROP    = 2'd2;

  logic [WIDTH:0] mem [DEPTH];
  logic [1:0]     state;
  logic [AW:0]    wr_ptr;
  logic [AW:0]    cmt_ptr;
  logic [AW:0]    rd_ptr;

  logic frame_word;
  logic full;
  logic do_write;
  logic overflow;
  logic commit;
  logic pop;
  logic pop_last;

  // Fullness uses pre-pop occupancy, so a same-cycle pop never rescues a write.
  assign frame_word = word_valid && ((state == CAPTURE) || ((state == IDLE) && match));
  assign full       = (wr_ptr - rd_ptr) == PTR_DEPTH;
  assign do_write   = frame_word && !full && !clear;
  assign overflow   = frame_word && full && !clear;
  assign commit     = do_write && frame_end;
  assign pop        = rd_en && !empty;
  assign pop_last   = pop && rd_last;

  assign empty     = (rd_ptr == cmt_ptr);
  assign rd_data   = mem[rd_ptr[AW-1:0]][WIDTH-1:0];
  assign rd_last   = mem[rd_ptr[AW-1:0]][WIDTH];
  assign capturing = (state == CAPTURE);

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr[AW-1:0]] <= {frame_end, word_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      cmt_ptr     <= '0;
      rd_ptr      <= '0;
      frame_count <= '0;
      dropped     <= 1'b0;
    end else begin
      dropped <= overflow;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (commit && !pop_last) begin
        frame_count <= frame_count + PTR_ONE;
      end else if (!commit && pop_last) begin
        frame_count <= frame_count - PTR_ONE;
      end
      // Uncommitted words are abandoned by rewinding the write pointer to the last commit.
      if (clear) begin
        state  <= IDLE;
        wr_ptr <= cmt_ptr;
      end else if (overflow) begin
        wr_ptr <= cmt_ptr;
        state  <= frame_end ? IDLE : DROP;
      end else if (do_write) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (frame_end) begin
          cmt_ptr <= wr_ptr + PTR_ONE;
          state   <= IDLE;
        end else begin
          state <= CAPTURE;
        end
      end else if ((state == DROP) && word_valid && frame_end) begin
        state <= IDLE;
      end
    end
  end

`ifdef CAPTURE_DROP_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= 16'd0;
    end else if (overflow && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule
